tlb_ctrl: RTL and testbench

- CP0-side sequencer that drives the TLB maintenance interface: config word, index, write enable, probe and read index.
- Executes TLBP, TLBR, TLBWI and TLBWR issued by the pipeline. Builds the 86-bit entry from EntryHi, EntryLo0 and EntryLo1.
- Captures probe and read results and returns them as CP0 register write-backs.
- Owns the Random register.

---
 rtl/tlb_ctrl_if.sv | 22 ++
 rtl/tlb_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_tlb_ctrl.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/tlb_ctrl_if.sv
// TLB maintenance bus between the CP0 sequencer (master) and the TLB array (slave).
interface tlb_ctrl_if #(
  parameter int IDX_W = 4
);
  logic [85:0]      tlb_config;
  logic [IDX_W-1:0] tlb_config_index;
  logic             tlb_we;
  logic             tlb_p;
  logic [31:0]      tlb_p_res_i;
  logic [IDX_W-1:0] tlb_read_index;
  logic [85:0]      tlb_read_config_i;

  modport master (
    output tlb_config, tlb_config_index, tlb_we, tlb_p, tlb_read_index,
    input  tlb_p_res_i, tlb_read_config_i
  );

  modport slave (
    input  tlb_config, tlb_config_index, tlb_we, tlb_p, tlb_read_index,
    output tlb_p_res_i, tlb_read_config_i
  );
endinterface

// File: rtl/tlb_ctrl.sv
// CP0-side sequencer for TLBP/TLBR/TLBWI/TLBWR; owns the Random register.
// Defining TLB_CTRL_PERF_EN adds saturating write and probe-miss counters.
module tlb_ctrl #(
  parameter int IDX_W   = 4,
  parameter int ENTRIES = 1 << IDX_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       cmd,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  output logic             done,
  input  logic [31:0]      entryhi_i,
  input  logic [31:0]      entrylo0_i,
  input  logic [31:0]      entrylo1_i,
  input  logic [31:0]      index_i,
  input  logic [IDX_W-1:0] wired_i,
  input  logic             wired_we,
  output logic [IDX_W-1:0] random_o,
  tlb_ctrl_if.master       tlb,
  output logic [31:0]      entryhi_o,
  output logic [31:0]      entrylo0_o,
  output logic [31:0]      entrylo1_o,
  output logic [31:0]      index_o,
  output logic             entryhi_we,
  output logic             entrylo0_we,
  output logic             entrylo1_we,
  output logic             index_we
`ifdef TLB_CTRL_PERF_EN
  ,
  output logic [31:0]      perf_write_cnt,
  output logic [31:0]      perf_probe_miss_cnt
`endif
);

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;
  typedef enum logic [1:0] {CMD_TLBP, CMD_TLBR, CMD_TLBWI, CMD_TLBWR} cmd_t;

  localparam logic [IDX_W-1:0] RAND_TOP = IDX_W'(ENTRIES - 1);

  state_t           state_q, state_d;
  cmd_t             cmd_q;
  logic [7:0]       asid_q;
  logic [18:0]      vpn2_q;
  logic [25:0]      lo0_q, lo1_q;
  logic [IDX_W-1:0] index_q, rand_lat_q, random_q;
  logic             p_miss_q;
  logic [IDX_W-1:0] p_idx_q;
  logic [7:0]       rd_asid_q;
  logic [18:0]      rd_vpn2_q;
  logic [25:0]      rd_lo0_q, rd_lo1_q;
  logic             we_s, p_s, g_s;
  logic             unused_bits;

  assign unused_bits = ^{entryhi_i[12:8], entrylo0_i[31:26], entrylo1_i[31:26],
                         index_i[31:IDX_W], tlb.tlb_p_res_i[30:IDX_W],
                         tlb.tlb_read_config_i[77:71]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (cmd_valid) state_d = EXEC;
      EXEC:    state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cmd_ready   = 1'b0;
    done        = 1'b0;
    we_s        = 1'b0;
    p_s         = 1'b0;
    entryhi_we  = 1'b0;
    entrylo0_we = 1'b0;
    entrylo1_we = 1'b0;
    index_we    = 1'b0;
    entryhi_o   = 32'd0;
    entrylo0_o  = 32'd0;
    entrylo1_o  = 32'd0;
    index_o     = 32'd0;
    case (state_q)
      IDLE: cmd_ready = 1'b1;
      EXEC: begin
        we_s = (cmd_q == CMD_TLBWI) || (cmd_q == CMD_TLBWR);
        p_s  = (cmd_q == CMD_TLBP);
      end
      DONE: begin
        done = 1'b1;
        case (cmd_q)
          CMD_TLBP: begin
            index_we = 1'b1;
            index_o  = {p_miss_q, {(31 - IDX_W){1'b0}}, p_idx_q};
          end
          CMD_TLBR: begin
            entryhi_we  = 1'b1;
            entrylo0_we = 1'b1;
            entrylo1_we = 1'b1;
            entryhi_o   = {rd_vpn2_q, 5'b0, rd_asid_q};
            entrylo0_o  = {6'b0, rd_lo0_q};
            entrylo1_o  = {6'b0, rd_lo1_q};
          end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  // Operands are frozen at acceptance so the TLB never sees live CP0 values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cmd_q      <= CMD_TLBP;
      asid_q     <= '0;
      vpn2_q     <= '0;
      lo0_q      <= '0;
      lo1_q      <= '0;
      index_q    <= '0;
      rand_lat_q <= '0;
    end else if (state_q == IDLE && cmd_valid) begin
      cmd_q      <= cmd_t'(cmd);
      asid_q     <= entryhi_i[7:0];
      vpn2_q     <= entryhi_i[31:13];
      lo0_q      <= entrylo0_i[25:0];
      lo1_q      <= entrylo1_i[25:0];
      index_q    <= index_i[IDX_W-1:0];
      rand_lat_q <= random_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      p_miss_q  <= 1'b0;
      p_idx_q   <= '0;
      rd_asid_q <= '0;
      rd_vpn2_q <= '0;
      rd_lo0_q  <= '0;
      rd_lo1_q  <= '0;
    end else if (state_q == EXEC) begin
      if (cmd_q == CMD_TLBP) begin
        p_miss_q <= tlb.tlb_p_res_i[31];
        p_idx_q  <= tlb.tlb_p_res_i[IDX_W-1:0];
      end
      if (cmd_q == CMD_TLBR) begin
        rd_asid_q <= tlb.tlb_read_config_i[85:78];
        rd_vpn2_q <= tlb.tlb_read_config_i[70:52];
        rd_lo0_q  <= tlb.tlb_read_config_i[51:26];
        rd_lo1_q  <= tlb.tlb_read_config_i[25:0];
      end
    end
  end

  // Wired at or above the top entry leaves nothing to randomise, so Random parks at the top.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      random_q <= RAND_TOP;
    else if (wired_we || wired_i >= RAND_TOP || random_q == wired_i)
      random_q <= RAND_TOP;
    else
      random_q <= random_q - IDX_W'(1);
  end

  assign random_o = random_q;

  // A page pair is global only if both halves say so; the stored G bits are forced equal.
  assign g_s                  = lo0_q[0] & lo1_q[0];
  assign tlb.tlb_config       = {asid_q, 7'b0, vpn2_q, lo0_q[25:1], g_s, lo1_q[25:1], g_s};
  assign tlb.tlb_config_index = (cmd_q == CMD_TLBWR) ? rand_lat_q : index_q;
  assign tlb.tlb_read_index   = index_q;
  assign tlb.tlb_we           = we_s;
  assign tlb.tlb_p            = p_s;

`ifdef TLB_CTRL_PERF_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_write_cnt      <= 32'd0;
      perf_probe_miss_cnt <= 32'd0;
    end else begin
      if (we_s && perf_write_cnt != 32'hFFFF_FFFF)
        perf_write_cnt <= perf_write_cnt + 32'd1;
      if (p_s && tlb.tlb_p_res_i[31] && perf_probe_miss_cnt != 32'hFFFF_FFFF)
        perf_probe_miss_cnt <= perf_probe_miss_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_tlb_ctrl.sv
// Self-checking bench for tlb_ctrl with a behavioural TLB array and CP0 reference model.
module tb_tlb_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  cmd = 2'd0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready, done;
  logic [31:0] entryhi_i = '0, entrylo0_i = '0, entrylo1_i = '0, index_i = '0;
  logic [3:0]  wired_i = 4'd0;
  logic        wired_we = 1'b0;
  logic [3:0]  random_o;
  logic [31:0] entryhi_o, entrylo0_o, entrylo1_o, index_o;
  logic        entryhi_we, entrylo0_we, entrylo1_we, index_we;
`ifdef TLB_CTRL_PERF_EN
  logic [31:0] perf_write_cnt, perf_probe_miss_cnt;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  tlb_ctrl_if #(.IDX_W(4)) tbus ();

  tlb_ctrl #(.IDX_W(4)) dut (
    .clk(clk), .rst(rst), .cmd(cmd), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .done(done), .entryhi_i(entryhi_i), .entrylo0_i(entrylo0_i), .entrylo1_i(entrylo1_i),
    .index_i(index_i), .wired_i(wired_i), .wired_we(wired_we), .random_o(random_o),
    .tlb(tbus), .entryhi_o(entryhi_o), .entrylo0_o(entrylo0_o), .entrylo1_o(entrylo1_o),
    .index_o(index_o), .entryhi_we(entryhi_we), .entrylo0_we(entrylo0_we),
    .entrylo1_we(entrylo1_we), .index_we(index_we)
`ifdef TLB_CTRL_PERF_EN
    , .perf_write_cnt(perf_write_cnt), .perf_probe_miss_cnt(perf_probe_miss_cnt)
`endif
  );

  // Behavioural TLB: stores written words, probes lowest matching index, reads combinationally.
  logic [85:0] tlb_mem [16] = '{default: '0};
  logic        tlb_vld [16] = '{default: 1'b0};

  always @(posedge clk)
    if (tbus.tlb_we) begin
      tlb_mem[tbus.tlb_config_index] <= tbus.tlb_config;
      tlb_vld[tbus.tlb_config_index] <= 1'b1;
    end

  always_comb begin
    tbus.tlb_p_res_i = 32'h8000_0000;
    for (int i = 15; i >= 0; i--)
      if (tlb_vld[i] && tlb_mem[i][70:52] == tbus.tlb_config[70:52] &&
          (tlb_mem[i][0] || tlb_mem[i][85:78] == tbus.tlb_config[85:78]))
        tbus.tlb_p_res_i = 32'(i);
  end

  assign tbus.tlb_read_config_i = tlb_mem[tbus.tlb_read_index];

  // Reference state: architectural readback values per index and the expected Random.
  logic [31:0] ref_hi [16] = '{default: '0};
  logic [31:0] ref_lo0 [16] = '{default: '0};
  logic [31:0] ref_lo1 [16] = '{default: '0};
  logic        ref_vld [16] = '{default: 1'b0};
  logic [3:0]  m_rand = 4'd15;

  always @(posedge clk or negedge rst)
    if (!rst) m_rand = 4'd15;
    else if (wired_we || wired_i >= 4'd15 || m_rand == wired_i) m_rand = 4'd15;
    else m_rand = m_rand - 4'd1;

  function automatic logic [85:0] exp_cfg(input logic [31:0] hi, lo0, lo1);
    logic [31:0] g;
    g = {31'b0, lo0[0] & lo1[0]};
    return (86'(hi & 32'hFF) << 78) | (86'(hi >> 13) << 52) |
           (86'((lo0 & 32'h03FF_FFFE) | g) << 26) | 86'((lo1 & 32'h03FF_FFFE) | g);
  endfunction

  task automatic ref_write(input int i, input logic [31:0] hi, lo0, lo1);
    logic [31:0] g;
    g = {31'b0, lo0[0] & lo1[0]};
    ref_hi[i]  = hi & 32'hFFFF_E0FF;
    ref_lo0[i] = (lo0 & 32'h03FF_FFFE) | g;
    ref_lo1[i] = (lo1 & 32'h03FF_FFFE) | g;
    ref_vld[i] = 1'b1;
  endtask

  function automatic logic [31:0] ref_probe(input logic [31:0] hi);
    for (int i = 0; i < 16; i++)
      if (ref_vld[i] && ref_hi[i][31:13] == hi[31:13] &&
          (ref_lo0[i][0] || ref_hi[i][7:0] == hi[7:0]))
        return 32'(i);
    return 32'h8000_0000;
  endfunction

  task automatic applyStimulus(input logic [1:0] c, input logic [31:0] hi, lo0, lo1, ix);
    cmd = c; entryhi_i = hi; entrylo0_i = lo0; entrylo1_i = lo1; index_i = ix;
    cmd_valid = 1'b1;
  endtask

  task automatic test_reset;
    logic [3:0] exp_r;
    #2 rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (random_o !== 4'd15) begin errors++; $display("[TB] FAIL rst_random: got %0d want 15", random_o); end
    checks++; if ({cmd_ready, done, tbus.tlb_we, tbus.tlb_p} !== 4'b1000) begin errors++; $display("[TB] FAIL rst_ctrl: got %b want 1000", {cmd_ready, done, tbus.tlb_we, tbus.tlb_p}); end
    checks++; if (tbus.tlb_config !== 86'd0 || index_o !== 32'd0) begin errors++; $display("[TB] FAIL rst_data: cfg %0h idx %0h want 0", tbus.tlb_config, index_o); end
    rst = 1'b1;
    for (int k = 1; k <= 17; k++) begin
      @(negedge clk);
      exp_r = 4'((k < 16) ? 15 - k : 31 - k);
      checks++; if (random_o !== exp_r) begin errors++; $display("[TB] FAIL random_seq%0d: got %0d want %0d", k, random_o, exp_r); end
    end
  endtask

  task automatic test_tlbwi;
    applyStimulus(2'd2, 32'h1234_60AB, 32'h0000_1017, 32'h0000_2016, 32'd5);
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("[TB] FAIL wi_ready: got %b want 1", cmd_ready); end
    @(negedge clk);
    cmd_valid = 1'b0;
    checks++; if ({tbus.tlb_we, tbus.tlb_p, done} !== 3'b100) begin errors++; $display("[TB] FAIL wi_exec_ctrl: got %b want 100", {tbus.tlb_we, tbus.tlb_p, done}); end
    checks++; if (tbus.tlb_config_index !== 4'd5) begin errors++; $display("[TB] FAIL wi_index: got %0d want 5", tbus.tlb_config_index); end
    checks++; if (tbus.tlb_config[70:52] !== 19'h091A3 || tbus.tlb_config[85:78] !== 8'hAB) begin errors++; $display("[TB] FAIL wi_vpn_asid: got %h/%h want 091a3/ab", tbus.tlb_config[70:52], tbus.tlb_config[85:78]); end
    checks++; if ({tbus.tlb_config[26], tbus.tlb_config[0]} !== 2'b00) begin errors++; $display("[TB] FAIL wi_gbits: got %b want 00", {tbus.tlb_config[26], tbus.tlb_config[0]}); end
    checks++; if (tbus.tlb_config !== exp_cfg(32'h1234_60AB, 32'h0000_1017, 32'h0000_2016)) begin errors++; $display("[TB] FAIL wi_config: got %h want %h", tbus.tlb_config, exp_cfg(32'h1234_60AB, 32'h0000_1017, 32'h0000_2016)); end
    ref_write(5, 32'h1234_60AB, 32'h0000_1017, 32'h0000_2016);
    @(negedge clk);
    checks++; if ({done, tbus.tlb_we, entryhi_we, entrylo0_we, entrylo1_we, index_we} !== 6'b100000) begin errors++; $display("[TB] FAIL wi_done: got %b want 100000", {done, tbus.tlb_we, entryhi_we, entrylo0_we, entrylo1_we, index_we}); end
    @(negedge clk);
    checks++; if ({done, cmd_ready} !== 2'b01) begin errors++; $display("[TB] FAIL wi_after: got %b want 01", {done, cmd_ready}); end
  endtask

  task automatic test_tlbp;
    logic [31:0] hi_set [2];
    hi_set[0] = 32'h1234_60AB;
    hi_set[1] = 32'h7777_7011;
    for (int t = 0; t < 2; t++) begin
      applyStimulus(2'd0, hi_set[t], 32'd0, 32'd0, 32'd0);
      @(negedge clk);
      cmd_valid = 1'b0;
      checks++; if ({tbus.tlb_p, tbus.tlb_we} !== 2'b10) begin errors++; $display("[TB] FAIL p%0d_exec: got %b want 10", t, {tbus.tlb_p, tbus.tlb_we}); end
      @(negedge clk);
      checks++; if ({done, index_we, entryhi_we} !== 3'b110) begin errors++; $display("[TB] FAIL p%0d_strobes: got %b want 110", t, {done, index_we, entryhi_we}); end
      checks++; if (index_o !== ref_probe(hi_set[t])) begin errors++; $display("[TB] FAIL p%0d_index: got %h want %h", t, index_o, ref_probe(hi_set[t])); end
      checks++; if (index_o !== (t == 0 ? 32'h0000_0005 : 32'h8000_0000)) begin errors++; $display("[TB] FAIL p%0d_const: got %h", t, index_o); end
      @(negedge clk);
      checks++; if ({index_we, index_o} !== 33'd0) begin errors++; $display("[TB] FAIL p%0d_idle: got %b/%h want 0", t, index_we, index_o); end
    end
  endtask

  task automatic test_tlbr;
    applyStimulus(2'd1, 32'hFFFF_FFFF, 32'd0, 32'd0, 32'd5);
    @(negedge clk);
    cmd_valid = 1'b0;
    checks++; if (tbus.tlb_read_index !== 4'd5 || {tbus.tlb_we, tbus.tlb_p, entryhi_we} !== 3'b000) begin errors++; $display("[TB] FAIL r_exec: idx %0d ctrl %b", tbus.tlb_read_index, {tbus.tlb_we, tbus.tlb_p, entryhi_we}); end
    @(negedge clk);
    checks++; if ({done, entryhi_we, entrylo0_we, entrylo1_we, index_we} !== 5'b11110) begin errors++; $display("[TB] FAIL r_strobes: got %b want 11110", {done, entryhi_we, entrylo0_we, entrylo1_we, index_we}); end
    checks++; if (entryhi_o !== 32'h1234_60AB) begin errors++; $display("[TB] FAIL r_hi: got %h want 123460ab", entryhi_o); end
    checks++; if (entrylo0_o !== 32'h0000_1016 || entrylo1_o !== 32'h0000_2016) begin errors++; $display("[TB] FAIL r_lo: got %h/%h want 1016/2016", entrylo0_o, entrylo1_o); end
    @(negedge clk);
    checks++; if ({entryhi_we, entrylo0_we, entrylo1_we} !== 3'b000 || entryhi_o !== 32'd0) begin errors++; $display("[TB] FAIL r_idle: got %b/%h want 0", {entryhi_we, entrylo0_we, entrylo1_we}, entryhi_o); end
  endtask

  task automatic test_random_wired;
    logic [3:0] target [2];
    target[0] = 4'd8;
    target[1] = 4'd12;
    wired_i = 4'd8; wired_we = 1'b1;
    @(negedge clk);
    wired_we = 1'b0;
    checks++; if (random_o !== 4'd15) begin errors++; $display("[TB] FAIL wired_reload: got %0d want 15", random_o); end
    for (int t = 0; t < 2; t++) begin
      for (int n = 0; n < 40 && m_rand != target[t]; n++) @(negedge clk);
      checks++; if (m_rand != target[t]) begin errors++; $display("[TB] FAIL wr%0d_wait: got %0d want %0d", t, m_rand, target[t]); end
      checks++; if (random_o !== target[t]) begin errors++; $display("[TB] FAIL wr%0d_random: got %0d want %0d", t, random_o, target[t]); end
      applyStimulus(2'd3, 32'h0ABC_D042, 32'h0000_0FFF, 32'h0300_0001, 32'd2);
      wired_we = (t == 1);
      @(negedge clk);
      cmd_valid = 1'b0; wired_we = 1'b0;
      checks++; if (tbus.tlb_we !== 1'b1 || tbus.tlb_config_index !== target[t]) begin errors++; $display("[TB] FAIL wr%0d_index: we %b idx %0d want 1/%0d", t, tbus.tlb_we, tbus.tlb_config_index, target[t]); end
      checks++; if (random_o !== 4'd15) begin errors++; $display("[TB] FAIL wr%0d_next: got %0d want 15", t, random_o); end
      ref_write(int'(target[t]), 32'h0ABC_D042, 32'h0000_0FFF, 32'h0300_0001);
      @(negedge clk);
      checks++; if (done !== 1'b1) begin errors++; $display("[TB] FAIL wr%0d_done: got %b want 1", t, done); end
      @(negedge clk);
      if (t == 0)
        for (int n = 0; n < 100; n++) begin
          checks++; if (random_o < 4'd8 || random_o !== m_rand) begin errors++; $display("[TB] FAIL random_range%0d: got %0d want %0d", n, random_o, m_rand); end
          @(negedge clk);
        end
    end
  endtask

  task automatic test_back_to_back;
    logic [1:0]  c;
    logic [31:0] hi, lo0, lo1, ix, exp_ix, probe_exp;
    logic [3:0]  exp_str;
    int          j;
    for (int n = 0; n < 16; n++) begin
      c = (n < 4) ? 2'd2 : 2'($urandom_range(0, 3));
      hi = $urandom; lo0 = $urandom; lo1 = $urandom;
      ix = 32'($urandom_range(0, 15)) | ($urandom & 32'hFFFF_FFF0);
      j = $urandom_range(0, 15);
      if (c == 2'd0 && ref_vld[j] && $urandom_range(0, 1) == 1) hi = ref_hi[j] | ($urandom & 32'h0000_1F00);
      exp_ix = (c == 2'd3) ? 32'(m_rand) : (ix & 32'hF);
      probe_exp = ref_probe(hi);
      checks++; if (cmd_ready !== 1'b1) begin errors++; $display("[TB] FAIL b2b%0d_ready: got %b want 1", n, cmd_ready); end
      applyStimulus(c, hi, lo0, lo1, ix);
      @(negedge clk);
      entryhi_i = $urandom; entrylo0_i = $urandom; entrylo1_i = $urandom; index_i = $urandom; cmd = 2'($urandom);
      checks++; if ({cmd_ready, tbus.tlb_we, tbus.tlb_p} !== {1'b0, c[1], c == 2'd0}) begin errors++; $display("[TB] FAIL b2b%0d_exec: got %b want %b", n, {cmd_ready, tbus.tlb_we, tbus.tlb_p}, {1'b0, c[1], c == 2'd0}); end
      if (c[1]) begin
        checks++; if (tbus.tlb_config !== exp_cfg(hi, lo0, lo1) || 32'(tbus.tlb_config_index) !== exp_ix) begin errors++; $display("[TB] FAIL b2b%0d_write: got %h@%0d want %h@%0d", n, tbus.tlb_config, tbus.tlb_config_index, exp_cfg(hi, lo0, lo1), exp_ix); end
        ref_write(int'(exp_ix), hi, lo0, lo1);
      end
      @(negedge clk);
      exp_str = (c == 2'd0) ? 4'b0001 : (c == 2'd1) ? 4'b1110 : 4'b0000;
      checks++; if ({done, cmd_ready, entryhi_we, entrylo0_we, entrylo1_we, index_we} !== {2'b10, exp_str}) begin errors++; $display("[TB] FAIL b2b%0d_done: got %b want %b", n, {done, cmd_ready, entryhi_we, entrylo0_we, entrylo1_we, index_we}, {2'b10, exp_str}); end
      if (c == 2'd0) begin
        checks++; if (index_o !== probe_exp) begin errors++; $display("[TB] FAIL b2b%0d_probe: got %h want %h", n, index_o, probe_exp); end
      end else if (c == 2'd1) begin
        checks++; if ({entryhi_o, entrylo0_o, entrylo1_o} !== {ref_hi[ix[3:0]], ref_lo0[ix[3:0]], ref_lo1[ix[3:0]]}) begin errors++; $display("[TB] FAIL b2b%0d_read: got %h %h %h want %h %h %h", n, entryhi_o, entrylo0_o, entrylo1_o, ref_hi[ix[3:0]], ref_lo0[ix[3:0]], ref_lo1[ix[3:0]]); end
      end
      @(negedge clk);
    end
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset_mid;
    applyStimulus(2'd2, 32'h5555_5055, 32'h0000_0003, 32'h0000_0005, 32'd3);
    @(negedge clk);
    cmd_valid = 1'b0;
    checks++; if (tbus.tlb_we !== 1'b1) begin errors++; $display("[TB] FAIL mid_we_before: got %b want 1", tbus.tlb_we); end
    #2 rst = 1'b0;
    #1;
    checks++; if ({tbus.tlb_we, done, cmd_ready} !== 3'b001) begin errors++; $display("[TB] FAIL mid_async: got %b want 001", {tbus.tlb_we, done, cmd_ready}); end
    checks++; if (tbus.tlb_config !== 86'd0 || random_o !== 4'd15) begin errors++; $display("[TB] FAIL mid_data: cfg %h rnd %0d want 0/15", tbus.tlb_config, random_o); end
    @(negedge clk);
    rst = 1'b1;
    for (int n = 0; n < 3; n++) begin
      checks++; if ({done, tbus.tlb_we, cmd_ready} !== 3'b001) begin errors++; $display("[TB] FAIL mid_after%0d: got %b want 001", n, {done, tbus.tlb_we, cmd_ready}); end
      @(negedge clk);
    end
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset;
    test_tlbwi;
    test_tlbp;
    test_tlbr;
    test_random_wired;
    test_back_to_back;
    test_reset_mid;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
